// File: rtl/sample_packer.sv
// rtl/sample_packer.sv - packs a byte stream MSB-first into channel-tagged sample words (SAMPLE_PACKER_SIGN_EXTEND_EN: sign-extend upper word bits)
module sample_packer #(
    parameter int B   = 3,
    parameter int Nw  = 32,
    parameter int Nch = 2,
    parameter int Mch = (Nch > 1) ? $clog2(Nch) : 1
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [7:0]     in_data,
    input  logic           in_valid,
    output logic           in_ready,
    output logic [Nw-1:0]  out_data,
    output logic           out_valid,
    input  logic           out_ready,
    input  logic           clear,
    output logic [Mch-1:0] channel,
    output logic [1:0]     byte_count
);

    // Holds the leading B-1 bytes of the sample being assembled; older bytes
    // are shifted out completely before a sample finishes, so no flush is needed.
    logic [8*(B-1)-1:0] shift_q, shift_d;
    logic [1:0]         byte_count_q, byte_count_d;
    logic [Mch-1:0]     chan_ctr_q, chan_ctr_d;
    logic [Mch-1:0]     channel_q, channel_d;
    logic               out_valid_q, out_valid_d;
    logic [Nw-1:0]      out_data_q, out_data_d;

    logic               final_byte;
    logic               in_fire;
    logic [8*B-1:0]     sample_w;
    logic [Nw-1:0]      word_w;

    // Backpressure only reaches the final byte of a sample; clear blocks all input.
    always_comb begin
        final_byte = (byte_count_q == 2'(B - 1));
        in_ready   = !clear && (!final_byte || !out_valid_q || out_ready);
        in_fire    = in_valid && in_ready;
    end

    // Sample word assembly and widening of the sample to the output word.
    always_comb begin
        sample_w = {shift_q, in_data};
`ifdef SAMPLE_PACKER_SIGN_EXTEND_EN
        word_w = Nw'($signed(sample_w));
`else
        word_w = Nw'(sample_w);
`endif
    end

    // Next-state: byte shifting, word load, output handshake and clear.
    always_comb begin
        shift_d      = shift_q;
        byte_count_d = byte_count_q;
        chan_ctr_d   = chan_ctr_q;
        channel_d    = channel_q;
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;

        if (clear) begin
            // Drops the partial sample and any pending word, even one being taken now.
            byte_count_d = 2'd0;
            chan_ctr_d   = '0;
            out_valid_d  = 1'b0;
        end else begin
            if (out_valid_q && out_ready) begin
                out_valid_d = 1'b0;
            end
            if (in_fire) begin
                if (final_byte) begin
                    out_data_d   = word_w;
                    out_valid_d  = 1'b1;
                    channel_d    = chan_ctr_q;
                    chan_ctr_d   = (chan_ctr_q == Mch'(Nch - 1)) ? '0 : chan_ctr_q + 1'b1;
                    byte_count_d = 2'd0;
                end else begin
                    shift_d      = sample_w[8*(B-1)-1:0];
                    byte_count_d = byte_count_q + 2'd1;
                end
            end
        end
    end

    // State registers with asynchronous active-high reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shift_q      <= '0;
            byte_count_q <= 2'd0;
            chan_ctr_q   <= '0;
            channel_q    <= '0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
        end else begin
            shift_q      <= shift_d;
            byte_count_q <= byte_count_d;
            chan_ctr_q   <= chan_ctr_d;
            channel_q    <= channel_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
        end
    end

    assign out_data   = out_data_q;
    assign out_valid  = out_valid_q;
    assign channel    = channel_q;
    assign byte_count = byte_count_q;

endmodule

// File: tb/tb_sample_packer.sv
// tb/tb_sample_packer.sv - randomized and directed bench for sample_packer against a queue-based model
module tb_sample_packer;

    localparam int B   = 3;
    localparam int NW  = 32;
    localparam int NCH = 3;
    localparam int MCH = 2;

    logic           clk = 1'b0;
    logic           reset = 1'b0;
    logic [7:0]     in_data = 8'h00;
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic [NW-1:0]  out_data;
    logic           out_valid;
    logic           out_ready = 1'b0;
    logic           clear = 1'b0;
    logic [MCH-1:0] channel;
    logic [1:0]     byte_count;

    sample_packer #(.B(B), .Nw(NW), .Nch(NCH), .Mch(MCH)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .clear      (clear),
        .channel    (channel),
        .byte_count (byte_count)
    );

    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_miss = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: accepted bytes of the partial sample, the word held at the output.
    logic [7:0]    m_bytes[$];
    bit            m_valid;
    logic [NW-1:0] m_word;
    int            m_ch;
    int            m_ctr;

    task automatic m_reset();
        m_bytes.delete();
        m_valid = 0;
        m_word  = '0;
        m_ch    = 0;
        m_ctr   = 0;
    endtask

    function automatic logic [NW-1:0] m_pack();
        longint v = 0;
        for (int k = 0; k < B; k++) v = v * 256 + longint'(m_bytes[k]);
`ifdef SAMPLE_PACKER_SIGN_EXTEND_EN
        if (v >= (longint'(1) << (8*B-1))) v = v - (longint'(1) << (8*B));
`endif
        return NW'(v);
    endfunction

    function automatic bit m_in_ready();
        return !clear && (m_bytes.size() != B-1 || !m_valid || out_ready);
    endfunction

    task automatic m_edge();
        bit acc;
        acc = in_valid && m_in_ready();
        if (clear) begin
            m_bytes.delete();
            m_ctr   = 0;
            m_valid = 0;
        end else begin
            if (m_valid && out_ready) m_valid = 0;
            if (acc) begin
                m_bytes.push_back(in_data);
                if (m_bytes.size() == B) begin
                    m_word  = m_pack();
                    m_valid = 1;
                    m_ch    = m_ctr;
                    m_ctr   = (m_ctr + 1) % NCH;
                    m_bytes.delete();
                end
            end
        end
    endtask

    task automatic check_outputs();
        chk("in_ready",   {63'd0, in_ready},   {63'd0, m_in_ready()});
        chk("out_valid",  {63'd0, out_valid},  {63'd0, m_valid});
        chk("out_data",   64'(out_data),       64'(m_word));
        chk("channel",    64'(channel),        64'(m_ch));
        chk("byte_count", 64'(byte_count),     64'(m_bytes.size()));
    endtask

    // One clock: drive at the falling edge, check mid-cycle, step the model at the rising edge.
    task automatic cycle(input bit v, input logic [7:0] d, input bit ordy, input bit clr);
        @(negedge clk);
        in_valid  = v;
        in_data   = d;
        out_ready = ordy;
        clear     = clr;
        #1 check_outputs();
        @(posedge clk);
        m_edge();
    endtask

    logic [7:0] stream [6];

    initial begin
        m_reset();
        #1 reset = 1'b1;
        #1;
        chk("rst_out_valid",  {63'd0, out_valid}, 64'd0);
        chk("rst_out_data",   64'(out_data),      64'd0);
        chk("rst_channel",    64'(channel),       64'd0);
        chk("rst_byte_count", 64'(byte_count),    64'd0);
        @(negedge clk);
        reset = 1'b0;

        // Back-to-back stream with the consumer always ready.
        stream = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC};
        for (int i = 0; i < 3; i++) cycle(1, stream[i], 1, 0);
        #1;
        chk("w0_data",  64'(out_data), 64'h00123456);
        chk("w0_ch",    64'(channel),  64'd0);
        chk("w0_valid", {63'd0, out_valid}, 64'd1);
        for (int i = 3; i < 6; i++) cycle(1, stream[i], 1, 0);
        #1;
        chk("w1_data", 64'(out_data), 64'h00789ABC);
        chk("w1_ch",   64'(channel),  64'd1);

        // Sign-extension boundary: top sample bit set.
        cycle(1, 8'h80, 1, 0);
        cycle(1, 8'h00, 1, 0);
        cycle(1, 8'h01, 1, 0);
        #1;
`ifdef SAMPLE_PACKER_SIGN_EXTEND_EN
        chk("sx_data", 64'(out_data), 64'hFF800001);
`else
        chk("sx_data", 64'(out_data), 64'h00800001);
`endif
        chk("sx_ch", 64'(channel), 64'd2);
        cycle(0, 8'h00, 1, 0);

        // Output stall: next sample's leading bytes pass, final byte waits.
        for (int i = 0; i < 3; i++) cycle(1, 8'(8'h21 + i), 0, 0);
        cycle(1, 8'h24, 0, 0);
        cycle(1, 8'h25, 0, 0);
        cycle(1, 8'h26, 0, 0);
        cycle(1, 8'h26, 0, 0);
        #1;
        chk("stall_bc",    64'(byte_count),      64'd2);
        chk("stall_ready", {63'd0, in_ready},    64'd0);
        chk("stall_hold",  64'(out_data),        64'h00212223);
        cycle(1, 8'h26, 1, 0);
        #1;
        chk("stall_w2",    64'(out_data),        64'h00242526);
        chk("stall_ch",    64'(channel),         64'd1);
        cycle(0, 8'h00, 1, 0);

        // Clear with a pending word and a partial sample.
        for (int i = 0; i < 5; i++) cycle(1, 8'(8'h40 + i), 0, 0);
        cycle(1, 8'h55, 1, 1);
        #1;
        chk("clr_valid", {63'd0, out_valid}, 64'd0);
        chk("clr_bc",    64'(byte_count),    64'd0);
        for (int i = 0; i < 3; i++) cycle(1, 8'(8'h61 + i), 1, 0);
        #1;
        chk("clr_w",  64'(out_data), 64'h00616263);
        chk("clr_ch", 64'(channel),  64'd0);

        // Asynchronous reset between edges, mid-sample with a word pending.
        cycle(1, 8'h71, 0, 0);
        #2;
        in_valid = 1'b0;
        clear    = 1'b0;
        reset    = 1'b1;
        #1;
        chk("arst_valid", {63'd0, out_valid}, 64'd0);
        chk("arst_data",  64'(out_data),      64'd0);
        chk("arst_ch",    64'(channel),       64'd0);
        chk("arst_bc",    64'(byte_count),    64'd0);
        m_reset();
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) cycle(1, 8'(8'h81 + i), 1, 0);
        #1;
        chk("arst_w",  64'(out_data), 64'h00818283);
        chk("arst_wc", 64'(channel),  64'd0);

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            cycle(($urandom % 4) != 0, 8'($urandom), ($urandom % 4) != 0, ($urandom % 40) == 0);
        end
        @(negedge clk);
        in_valid = 1'b0;
        clear    = 1'b0;
        #1 check_outputs();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
